// File: rtl/btp_pkg.sv
// Shared encodings and PC field helpers for the branch target predictor.
package btp_pkg;

  localparam int unsigned BTP_ENTRIES_DEFAULT = 16;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // The index is returned zero-extended to 8 bits; callers truncate to their own index width.
  function automatic logic [7:0] btp_index(input logic [31:0] pc, input int unsigned index_w);
    logic [31:0] mask;
    mask = (32'd1 << index_w) - 32'd1;
    return 8'((pc >> 2) & mask);
  endfunction

  function automatic logic [29:0] btp_tag(input logic [31:0] pc, input int unsigned index_w);
    return 30'(pc >> (index_w + 2));
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
module sat_counter2
  import btp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: predicts in IF, resolves in ID.
// Optional macro BTP_STATS_EN adds resolve/mispredict statistic counters.
module branch_target_predictor
  import btp_pkg::*;
#(
  parameter int unsigned ENTRIES = BTP_ENTRIES_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IF_PC,
  output logic        IF_PredTaken,
  output logic [31:0] IF_PredTarget,
  input  logic        ID_Valid,
  input  logic        ID_Branch,
  input  logic        ID_Stall,
  input  logic [31:0] ID_PC,
  input  logic        ID_PredTaken,
  input  logic [31:0] ID_PredTarget,
  input  logic [31:0] ID_Target,
  input  logic        Cmp_Result,
  output logic        Redirect,
  output logic [31:0] Redirect_PC,
  output logic        Flush_IFID
`ifdef BTP_STATS_EN
  ,
  output logic [31:0] Stat_Branches,
  output logic [31:0] Stat_Mispredicts
`endif
);

  localparam int unsigned INDEX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 30 - INDEX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0]   if_tag, id_tag;
  logic               if_hit, id_hit, resolve, mispredict;
  logic [1:0]         ctr_d;

  assign if_idx = INDEX_W'(btp_index(IF_PC, INDEX_W));
  assign if_tag = TAG_W'(btp_tag(IF_PC, INDEX_W));
  assign id_idx = INDEX_W'(btp_index(ID_PC, INDEX_W));
  assign id_tag = TAG_W'(btp_tag(ID_PC, INDEX_W));

  assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign IF_PredTaken  = if_hit && ctr_q[if_idx][1];
  assign IF_PredTarget = IF_PredTaken ? target_q[if_idx] : IF_PC + 32'd4;

  // Reset masks resolve so a coincident branch neither redirects nor updates.
  assign resolve    = ID_Valid && ID_Branch && !ID_Stall && !Reset;
  assign mispredict = resolve && ((Cmp_Result != ID_PredTaken) ||
                      (Cmp_Result && ID_PredTaken && (ID_PredTarget != ID_Target)));
  assign Redirect    = mispredict;
  assign Flush_IFID  = mispredict;
  assign Redirect_PC = (mispredict && Cmp_Result) ? ID_Target : ID_PC + 32'd4;

  assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  sat_counter2 u_ctr (
    .ctr   (ctr_q[id_idx]),
    .taken (Cmp_Result),
    .next  (ctr_d)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (resolve) begin
      if (id_hit) begin
        ctr_q[id_idx] <= ctr_d;
      end else if (Cmp_Result) begin
        valid_q[id_idx] <= 1'b1;
        ctr_q[id_idx]   <= CTR_WT;
      end
    end
  end

  // Tags and targets are never reset; valid bits alone qualify them.
  always_ff @(posedge Clock) begin
    if (resolve && Cmp_Result) begin
      tag_q[id_idx]    <= id_tag;
      target_q[id_idx] <= ID_Target;
    end
  end

`ifdef BTP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (resolve && (stat_br_q != '1))    stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign Stat_Branches    = stat_br_q;
  assign Stat_Mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed scoreboard bench for branch_target_predictor (ENTRIES=16).
module tb_branch_target_predictor;
  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] IF_PC;
  logic        IF_PredTaken;
  logic [31:0] IF_PredTarget;
  logic        ID_Valid, ID_Branch, ID_Stall, ID_PredTaken, Cmp_Result;
  logic [31:0] ID_PC, ID_PredTarget, ID_Target;
  logic        Redirect, Flush_IFID;
  logic [31:0] Redirect_PC;
`ifdef BTP_STATS_EN
  logic [31:0] Stat_Branches, Stat_Mispredicts;
`endif

  branch_target_predictor #(.ENTRIES(16)) dut (
    .Clock(Clock), .Reset(Reset), .IF_PC(IF_PC),
    .IF_PredTaken(IF_PredTaken), .IF_PredTarget(IF_PredTarget),
    .ID_Valid(ID_Valid), .ID_Branch(ID_Branch), .ID_Stall(ID_Stall),
    .ID_PC(ID_PC), .ID_PredTaken(ID_PredTaken), .ID_PredTarget(ID_PredTarget),
    .ID_Target(ID_Target), .Cmp_Result(Cmp_Result),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC), .Flush_IFID(Flush_IFID)
`ifdef BTP_STATS_EN
    , .Stat_Branches(Stat_Branches), .Stat_Mispredicts(Stat_Mispredicts)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic id_drive(input logic v, input logic br, input logic st, input logic [31:0] pc,
                          input logic pt, input logic [31:0] ptgt, input logic [31:0] tgt,
                          input logic cmp);
    ID_Valid = v; ID_Branch = br; ID_Stall = st; ID_PC = pc;
    ID_PredTaken = pt; ID_PredTarget = ptgt; ID_Target = tgt; Cmp_Result = cmp;
  endtask

  task automatic id_idle();
    id_drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_redirect(input string t, input logic r, input logic [31:0] rpc);
    push({t, "_redirect"}, {31'd0, r});
    push({t, "_rpc"}, rpc);
    push({t, "_flush"}, {31'd0, r});
    #1;
    chk({31'd0, Redirect});
    chk(Redirect_PC);
    chk({31'd0, Flush_IFID});
  endtask

  task automatic expect_lookup(input string t, input logic [31:0] pc, input logic tk,
                               input logic [31:0] tgt);
    IF_PC = pc;
    push({t, "_predtaken"}, {31'd0, tk});
    push({t, "_predtarget"}, tgt);
    #1;
    chk({31'd0, IF_PredTaken});
    chk(IF_PredTarget);
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0050;
  localparam logic [31:0] PC_ = 32'h0040_0020;
  localparam logic [31:0] TA = 32'h0040_0100;

  initial begin
    Reset = 1'b1;
    IF_PC = PA;
    id_idle();
    next_cycle();
    next_cycle();
    Reset = 1'b0;
    expect_lookup("reset_lookup", PA, 1'b0, PA + 4);

    // first taken resolve allocates; same-cycle lookup still sees the old entry
    id_drive(1, 1, 0, PA, 0, PA + 4, TA, 1);
    expect_redirect("alloc", 1'b1, TA);
    expect_lookup("alloc_nobypass", PA, 1'b0, PA + 4);
    next_cycle();
    id_idle();
    expect_lookup("alloc_after", PA, 1'b1, TA);

    // predicted taken, actually not taken: ctr 10 -> 01
    id_drive(1, 1, 0, PA, 1, TA, TA, 0);
    expect_redirect("nt_mispred", 1'b1, PA + 4);
    next_cycle();
    id_idle();
    expect_lookup("nt_after", PA, 1'b0, PA + 4);

    // four correct taken resolves: 01 -> 10 -> 11 -> 11 -> 11
    for (int i = 0; i < 4; i++) begin
      id_drive(1, 1, 0, PA, 1, TA, TA, 1);
      expect_redirect("taken_ok", 1'b0, PA + 4);
      next_cycle();
    end
    id_drive(1, 1, 0, PA, 1, TA, TA, 0);
    expect_redirect("sat_nt", 1'b1, PA + 4);
    next_cycle();
    id_idle();
    expect_lookup("sat_after", PA, 1'b1, TA);

    // stalled not-taken resolve must neither redirect nor weaken ctr (10)
    id_drive(1, 1, 1, PA, 1, TA, TA, 0);
    expect_redirect("stall", 1'b0, PA + 4);
    next_cycle();
    id_drive(1, 0, 0, PA, 1, TA, TA, 0);
    expect_redirect("nonbranch", 1'b0, PA + 4);
    next_cycle();
    id_idle();
    expect_lookup("stall_after", PA, 1'b1, TA);

    // taken with a wrong predicted target redirects to the computed target
    id_drive(1, 1, 0, PA, 1, 32'h0040_0200, TA, 1);
    expect_redirect("tgt_mismatch", 1'b1, TA);
    next_cycle();

    // miss & not-taken leaves the entry invalid
    id_drive(1, 1, 0, PC_, 0, PC_ + 4, 32'h0040_0400, 0);
    expect_redirect("miss_nt", 1'b0, PC_ + 4);
    next_cycle();
    id_idle();
    expect_lookup("miss_nt_after", PC_, 1'b0, PC_ + 4);

    // alias: same index, different tag replaces the entry
    id_drive(1, 1, 0, PB, 0, PB + 4, 32'h0040_0300, 1);
    expect_redirect("alias", 1'b1, 32'h0040_0300);
    next_cycle();
    id_idle();
    expect_lookup("alias_old", PA, 1'b0, PA + 4);
    expect_lookup("alias_new", PB, 1'b1, 32'h0040_0300);

    // reset coincident with a taken resolve
    Reset = 1'b1;
    id_drive(1, 1, 0, PC_, 0, PC_ + 4, 32'h0040_0500, 1);
    expect_redirect("reset_resolve", 1'b0, PC_ + 4);
    next_cycle();
    Reset = 1'b0;
    id_idle();
    expect_lookup("reset_noalloc", PC_, 1'b0, PC_ + 4);
    expect_lookup("reset_cleared", PB, 1'b0, PB + 4);
`ifdef BTP_STATS_EN
    push("stat_branches", 32'd0);
    push("stat_mispredicts", 32'd0);
    chk(Stat_Branches);
    chk(Stat_Mispredicts);
`endif

    if (q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
- Predicts in IF; resolves in ID against the branch comparator's Result.
- On a misprediction it drives the PC redirect and the IF/ID flush.
- Upstream of the comparator (supplies the fetch prediction) and downstream of it (consumes Result).

Parameters:
- ENTRIES, 16, number of BTB entries (power of two, 4..256).
- INDEX_W, log2(ENTRIES), index width (derived; not overridden).
- TAG_W, 30-INDEX_W, stored tag width.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- IF_PC  in  32  fetch-stage PC
- IF_PredTaken  out  1  prediction: branch taken
- IF_PredTarget  out  32  predicted next PC
- ID_Valid  in  1  ID stage holds a real instruction
- ID_Branch  in  1  ID instruction is a conditional branch (BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ)
- ID_Stall  in  1  ID stage held this cycle
- ID_PC  in  32  PC of the ID instruction
- ID_PredTaken  in  1  IF_PredTaken piped through IF/ID
- ID_PredTarget  in  32  IF_PredTarget piped through IF/ID
- ID_Target  in  32  computed branch target (PC+4+offset<<2)
- Cmp_Result  in  1  comparator Result, 1 = taken
- Redirect  out  1  mispredict; PC mux must select Redirect_PC
- Redirect_PC  out  32  corrected next PC
- Flush_IFID  out  1  squash IF/ID register

Behaviour:
- Field extraction: index = PC[INDEX_W+1:2]; tag = PC[31:INDEX_W+2].
- Each entry holds: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational, IF):
  - hit = valid[idx] & tag match.
  - IF_PredTaken = hit & ctr[1].
  - IF_PredTarget = IF_PredTaken ? target : IF_PC+4.
  - Zero-cycle latency.
- Resolve = ID_Valid & ID_Branch & !ID_Stall. Bubbles, non-branches and stalled cycles cause no update and no redirect.
- Misprediction (combinational, same cycle as Cmp_Result), with taken = Cmp_Result:
  - mispredict = resolve & ((taken != ID_PredTaken) | (taken & ID_PredTaken & ID_PredTarget != ID_Target)).
  - Redirect = mispredict.
  - Redirect_PC = taken ? ID_Target : ID_PC+4.
  - Flush_IFID = Redirect.
  - When Redirect=0, Redirect_PC is don't-care; implement as ID_PC+4.
- Update (registered at posedge Clock on resolve; entry selected by ID_PC):
  - Hit: taken increments ctr (saturates at 11); not-taken decrements (saturates at 00). Taken also overwrites target with ID_Target.
  - Miss & taken: allocate (overwrite any occupant) with valid=1, tag, target=ID_Target, ctr=10.
  - Miss & not-taken: no change.
- Same-cycle read/write to one index: IF lookup sees pre-update contents (no bypass). The new state is visible on the next cycle.
- Reset:
  - Clears all valid bits and sets all ctr=01; tags and targets are untouched.
  - Consequence: IF_PredTaken=0 and IF_PredTarget=IF_PC+4 after reset.
  - Reset overrides a coincident update.
  - Redirect/Flush_IFID are combinational and are gated to 0 while Reset=1.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Optional Feature:
- Macro: BTP_STATS_EN.
- When defined:
  - Adds output ports Stat_Branches[31:0] and Stat_Mispredicts[31:0].
  - Stat_Branches increments on each resolve; Stat_Mispredicts increments on each mispredict.
  - Both counters saturate at 32'hFFFFFFFF and clear on Reset.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package btp_pkg holds:
  - counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - default ENTRIES;
  - functions btp_index(pc) and btp_tag(pc).
- One sub-module, sat_counter2: combinational next-state for a 2-bit saturating counter (inputs ctr, taken; output next).

Test Plan:
- Reset, then IF_PC=0x00400010 -> IF_PredTaken=0, IF_PredTarget=0x00400014.
- Resolve at ID_PC=0x00400010, ID_PredTaken=0, Cmp_Result=1, ID_Target=0x00400100:
  - same cycle: Redirect=1, Redirect_PC=0x00400100, Flush_IFID=1;
  - next cycle: IF_PC=0x00400010 gives PredTaken=1, Target=0x00400100.
- Same branch, predicted taken, Cmp_Result=0 -> Redirect=1, Redirect_PC=0x00400014; ctr 10->01; next lookup PredTaken=0.
- Alias test, ENTRIES=16: allocate 0x00400010 taken, then resolve 0x00400050 taken (same index, different tag) -> entry replaced; lookup of 0x00400010 misses (PredTaken=0).
- Four consecutive taken resolves saturate ctr at 11; one not-taken -> 10 and still predicts taken. Also a stalled resolve (ID_Stall=1) -> no Redirect, no state change.
- Reset asserted in the same cycle as a taken resolve -> Redirect=0, entry not allocated. With BTP_STATS_EN, both stat counters read 0 afterwards.
